// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding and register map.
// Imported by the transmitter and by the bus slave that decodes offsets.
package uart_pkg;

  // One-hot transmitter states
  typedef enum logic [3:0] {
    IDLE  = 4'h1,
    START = 4'h2,
    DATA  = 4'h4,
    STOP  = 4'h8
  } tx_state_t;

  // Register offsets (word index)
  typedef enum logic [2:0] {
    CTRL   = 3'd0,
    STATUS = 3'd1,
    BAUD   = 3'd2,
    TXDATA = 3'd3,
    RXDATA = 3'd4
  } reg_off_t;

  localparam int DATA_BITS = 8;
  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO, power-of-two depth, combinational head read.
// Ports: clk, rst, push/din, pop/dout, full, empty, level.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   LVL_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   LVL_FULL = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic             do_push;
  logic             do_pop;

  // A full FIFO refuses a push even if a pop frees a slot this cycle
  assign full    = (level == LVL_FULL);
  assign empty   = (level == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wptr] <= din;
    end
  end

  // Pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (do_push) begin
        wptr <= wptr + PTR_ONE;
      end
      if (do_pop) begin
        rptr <= rptr + PTR_ONE;
      end
      unique case ({do_push, do_pop})
        2'b10:   level <= level + LVL_ONE;
        2'b01:   level <= level - LVL_ONE;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: byte FIFO feeding an 8N1 serializer with
// per-frame latched baud divisor. Ports: clk, rst, tx_data/tx_valid/
// tx_ready (byte input), tx_en, baud_div, txd, tx_busy, fifo_level.
module uart_tx #(
  parameter int FIFO_DEPTH = 4,
  parameter int DIV_WIDTH  = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [7:0]                    tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  input  logic                          tx_en,
  input  logic [DIV_WIDTH-1:0]          baud_div,
  output logic                          txd,
  output logic                          tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  import uart_pkg::*;

  localparam logic [DIV_WIDTH-1:0] ONE = DIV_WIDTH'(1);

  tx_state_t             state;
  tx_state_t             state_n;
  logic [DIV_WIDTH-1:0]  cnt;
  logic [DIV_WIDTH-1:0]  cnt_n;
  logic [DIV_WIDTH-1:0]  div_q;
  logic [DIV_WIDTH-1:0]  div_n;
  logic [DIV_WIDTH-1:0]  eff_div;
  logic [7:0]            shreg;
  logic [7:0]            shreg_n;
  logic [2:0]            bit_idx;
  logic [2:0]            bit_n;
  logic                  txd_n;

  logic                  fifo_push;
  logic                  fifo_pop;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [7:0]            fifo_dout;
  logic                  can_start;
  logic                  bit_end;
  logic                  load;

  assign tx_ready  = !fifo_full;
  assign fifo_push = tx_valid && tx_ready;
  assign can_start = !fifo_empty && tx_en;
  assign bit_end   = (cnt == '0);
  assign eff_div   = (baud_div == '0) ? ONE : baud_div;
  assign tx_busy   = (state != IDLE) || !fifo_empty;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .din   (tx_data),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      div_q   <= '0;
      shreg   <= '0;
      bit_idx <= '0;
      txd     <= 1'b1;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      div_q   <= div_n;
      shreg   <= shreg_n;
      bit_idx <= bit_n;
      txd     <= txd_n;
    end
  end

  // Next-state logic
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: begin
        if (can_start) state_n = START;
      end
      START: begin
        if (bit_end) state_n = DATA;
      end
      DATA: begin
        if (bit_end && bit_idx == LAST_BIT) state_n = STOP;
      end
      STOP: begin
        if (bit_end) state_n = can_start ? START : IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Datapath and registered-output logic
  always_comb begin
    cnt_n    = cnt;
    div_n    = div_q;
    shreg_n  = shreg;
    bit_n    = bit_idx;
    fifo_pop = 1'b0;
    // Entering START from IDLE or STOP begins a fresh frame
    load = (state_n == START) && (state != START);
    if (load) begin
      fifo_pop = 1'b1;
      div_n    = eff_div;
      cnt_n    = eff_div - ONE;
      shreg_n  = fifo_dout;
      bit_n    = '0;
    end else if (state_n == IDLE) begin
      cnt_n = '0;
    end else if (bit_end) begin
      cnt_n = div_q - ONE;
      if (state == DATA) begin
        shreg_n = shreg >> 1;
        bit_n   = bit_idx + 3'd1;
      end
    end else begin
      cnt_n = cnt - ONE;
    end
    // txd is registered from the state being entered
    unique case (state_n)
      START:   txd_n = 1'b0;
      DATA:    txd_n = shreg_n[0];
      default: txd_n = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx against a frame-level model.
// Expected line waveform is derived from byte value and divisor.
module tb_uart_tx;

  localparam int DEPTH = 4;
  localparam int DW    = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  tx_data = '0;
  logic        tx_valid = 1'b0;
  logic        tx_ready;
  logic        tx_en = 1'b0;
  logic [DW-1:0] baud_div = '0;
  logic        txd;
  logic        tx_busy;
  logic [2:0]  fifo_level;

  int tests_run = 0;
  int fails = 0;
  logic [7:0] expq[$];

  uart_tx #(
    .FIFO_DEPTH (DEPTH),
    .DIV_WIDTH  (DW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .tx_en      (tx_en),
    .baud_div   (baud_div),
    .txd        (txd),
    .tx_busy    (tx_busy),
    .fifo_level (fifo_level)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic frame_bit(input logic [7:0] b, input int idx);
    if (idx == 0) return 1'b0;
    if (idx == 9) return 1'b1;
    return b[idx-1];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] b);
    int n = 0;
    tx_data  = b;
    tx_valid = 1'b1;
    while (!tx_ready && n < 500) begin
      tick();
      n++;
    end
    tick();
    tx_valid = 1'b0;
    expq.push_back(b);
    tests_run++;
    if (n >= 500) begin
      fails++;
      $display("FAIL push_accept: tx_ready=%b required 1", tx_ready);
    end
  endtask

  task automatic wait_start(input string name);
    int n = 0;
    while (txd !== 1'b0 && n < 2000) begin
      tick();
      n++;
    end
    tests_run++;
    if (txd !== 1'b0) begin
      fails++;
      $display("FAIL %s_start: txd=%b required 0 within 2000 cycles",
               name, txd);
    end
  endtask

  // Sample one whole frame; caller is positioned on its first cycle
  task automatic capture(input logic [7:0] b, input int div,
                         input string name);
    int bad = 0;
    int first = -1;
    logic fa = 1'b0;
    logic fe = 1'b0;
    logic e;
    for (int k = 0; k < 10 * div; k++) begin
      e = frame_bit(b, k / div);
      if (txd !== e) begin
        if (first < 0) begin
          first = k;
          fa = txd;
          fe = e;
        end
        bad++;
      end
      tick();
    end
    tests_run++;
    if (bad != 0) begin
      fails++;
      $display("FAIL %s_frame: byte %h div %0d, %0d bad cycles, cycle %0d txd=%b required %b",
               name, b, div, bad, first, fa, fe);
    end
  endtask

  task automatic check_idle(input string name);
    tests_run++;
    if (tx_busy !== 1'b0 || txd !== 1'b1) begin
      fails++;
      $display("FAIL %s_idle: tx_busy=%b txd=%b required 0 1",
               name, tx_busy, txd);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    tests_run++;
    if (txd !== 1'b1 || tx_ready !== 1'b1 || tx_busy !== 1'b0 ||
        fifo_level !== 3'd0) begin
      fails++;
      $display("FAIL reset: txd=%b ready=%b busy=%b level=%0d required 1 1 0 0",
               txd, tx_ready, tx_busy, fifo_level);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    baud_div = 4;
    tx_en    = 1'b1;
    tx_data  = 8'hA5;
    tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    tests_run++;
    if (txd !== 1'b1 || fifo_level !== 3'd1 || tx_busy !== 1'b1) begin
      fails++;
      $display("FAIL basic_accept: txd=%b level=%0d busy=%b required 1 1 1",
               txd, fifo_level, tx_busy);
    end
    tick();
    tests_run++;
    if (txd !== 1'b0 || fifo_level !== 3'd0) begin
      fails++;
      $display("FAIL basic_latency: txd=%b level=%0d required 0 0",
               txd, fifo_level);
    end
    capture(8'hA5, 4, "basic");
    check_idle("basic");
  endtask

  task automatic test_fifo_full();
    logic [7:0] b5;
    tx_en    = 1'b0;
    baud_div = 2;
    expq.delete();
    for (int i = 0; i < 4; i++) push_byte(8'($urandom));
    tests_run++;
    if (tx_ready !== 1'b0 || fifo_level !== 3'd4 || tx_busy !== 1'b1 ||
        txd !== 1'b1) begin
      fails++;
      $display("FAIL full_state: ready=%b level=%0d busy=%b txd=%b required 0 4 1 1",
               tx_ready, fifo_level, tx_busy, txd);
    end
    b5 = 8'($urandom);
    tx_data  = b5;
    tx_valid = 1'b1;
    repeat (3) tick();
    tests_run++;
    if (tx_ready !== 1'b0 || fifo_level !== 3'd4) begin
      fails++;
      $display("FAIL full_hold: ready=%b level=%0d required 0 4",
               tx_ready, fifo_level);
    end
    expq.push_back(b5);
    tx_en = 1'b1;
    fork
      begin
        int n = 0;
        while (!tx_ready && n < 100) begin
          tick();
          n++;
        end
        tick();
        tx_valid = 1'b0;
      end
      begin
        wait_start("full");
        repeat (5) capture(expq.pop_front(), 2, "full");
      end
    join
    check_idle("full");
  endtask

  task automatic test_back_to_back();
    tx_en    = 1'b0;
    baud_div = 2;
    expq.delete();
    push_byte(8'h00);
    push_byte(8'hFF);
    tx_en = 1'b1;
    wait_start("b2b");
    capture(8'h00, 2, "b2b_first");
    capture(8'hFF, 2, "b2b_second");
    check_idle("b2b");
  endtask

  task automatic test_div_zero();
    tx_en    = 1'b0;
    baud_div = 0;
    expq.delete();
    push_byte(8'h01);
    tx_en = 1'b1;
    wait_start("div0");
    capture(8'h01, 1, "div0");
    check_idle("div0");
  endtask

  task automatic test_baud_change();
    logic [7:0] a;
    logic [7:0] b;
    tx_en    = 1'b0;
    baud_div = 8;
    a = 8'($urandom);
    b = 8'($urandom);
    push_byte(a);
    push_byte(b);
    tx_en = 1'b1;
    wait_start("baudchg");
    fork
      begin
        repeat (30) tick();
        baud_div = 3;
      end
      begin
        capture(a, 8, "baudchg_old");
        capture(b, 3, "baudchg_new");
      end
    join
    check_idle("baudchg");
  endtask

  task automatic test_en_midframe();
    logic [7:0] a;
    logic [7:0] b;
    int lows = 0;
    tx_en    = 1'b0;
    baud_div = 3;
    a = 8'($urandom);
    b = 8'($urandom);
    push_byte(a);
    push_byte(b);
    tx_en = 1'b1;
    wait_start("en");
    fork
      begin
        repeat (5) tick();
        tx_en = 1'b0;
      end
      capture(a, 3, "en_finish");
    join
    for (int i = 0; i < 20; i++) begin
      if (txd !== 1'b1) lows++;
      tick();
    end
    tests_run++;
    if (lows != 0 || fifo_level !== 3'd1 || tx_busy !== 1'b1) begin
      fails++;
      $display("FAIL en_hold: low cycles=%0d level=%0d busy=%b required 0 1 1",
               lows, fifo_level, tx_busy);
    end
    tx_en = 1'b1;
    wait_start("en_resume");
    capture(b, 3, "en_resume");
    check_idle("en");
  endtask

  task automatic test_random();
    for (int r = 0; r < 4; r++) begin
      int div;
      int n;
      div = $urandom_range(0, 5);
      n   = $urandom_range(1, 4);
      tx_en    = 1'b0;
      baud_div = DW'(div);
      expq.delete();
      for (int i = 0; i < n; i++) push_byte(8'($urandom));
      tx_en = 1'b1;
      wait_start("rand");
      while (expq.size() != 0) begin
        capture(expq.pop_front(), (div == 0) ? 1 : div, "rand");
      end
      check_idle("rand");
    end
  endtask

  task automatic test_reset_midframe();
    int lows = 0;
    tx_en    = 1'b0;
    baud_div = 4;
    expq.delete();
    for (int i = 0; i < 3; i++) push_byte(8'($urandom));
    tx_en = 1'b1;
    wait_start("rstmid");
    repeat (15) tick();
    rst = 1'b1;
    #1;
    tests_run++;
    if (txd !== 1'b1 || fifo_level !== 3'd0 || tx_ready !== 1'b1 ||
        tx_busy !== 1'b0) begin
      fails++;
      $display("FAIL rstmid_abort: txd=%b level=%0d ready=%b busy=%b required 1 0 1 0",
               txd, fifo_level, tx_ready, tx_busy);
    end
    tick();
    rst = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (txd !== 1'b1 || fifo_level !== 3'd0) lows++;
      tick();
    end
    tests_run++;
    if (lows != 0) begin
      fails++;
      $display("FAIL rstmid_quiet: %0d active cycles required 0", lows);
    end
    expq.delete();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_fifo_full();
    test_back_to_back();
    test_div_zero();
    test_baud_change();
    test_en_midframe();
    test_random();
    test_reset_midframe();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 The block SHALL have parameter FIFO_DEPTH, default 4, meaning the number of transmit FIFO entries; it SHALL be a power of two, 2 or greater.
REQ-002 The block SHALL have parameter DIV_WIDTH, default 32 (XLEN), meaning the width of the baud divisor.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock, rising-edge.
REQ-004 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port tx_data, input, 8 bits: the byte offered by the register block (uart_txdata[7:0]).
REQ-006 The block SHALL have port tx_valid, input, 1 bit: tx_data is valid.
REQ-007 The block SHALL have port tx_ready, output, 1 bit: the FIFO can accept a byte.
REQ-008 The block SHALL have port tx_en, input, 1 bit: transmit enable (uart_ctrl[0]).
REQ-009 The block SHALL have port baud_div, input, DIV_WIDTH bits: the clock cycles per bit (uart_baud).
REQ-010 The block SHALL have port txd, output, 1 bit: the serial line, idle high.
REQ-011 The block SHALL have port tx_busy, output, 1 bit: frame in progress or FIFO non-empty (uart_status[0]).
REQ-012 The block SHALL have port fifo_level, output, $clog2(FIFO_DEPTH)+1 bits: the current FIFO occupancy.

Function
REQ-013 A byte SHALL be accepted at any rising edge where tx_valid && tx_ready.
REQ-014 tx_ready SHALL equal (fifo_level != FIFO_DEPTH); there is no full-FIFO bypass, even when a pop occurs in the same cycle.
REQ-015 A push and a pop in the same cycle SHALL leave fifo_level unchanged and store the data correctly.
REQ-016 The FIFO read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-017 The FSM SHALL be one-hot with four states: IDLE=4'h1, START=4'h2, DATA=4'h4, STOP=4'h8.
REQ-018 From IDLE, when the FIFO is non-empty and tx_en=1: pop the head into the shift register, latch the divisor, and enter START at the same edge.
REQ-019 The divisor SHALL be latched as baud_div, or 1 if baud_div=0; changes to baud_div mid-frame SHALL NOT affect the current frame.
REQ-020 Each bit SHALL last exactly div_latched cycles, timed by a down-counter of width DIV_WIDTH.
REQ-021 The frame SHALL be START (txd=0), then DATA with 8 bits LSB first, then STOP (txd=1): 10*div cycles total.
REQ-022 At the end of STOP, if the FIFO is non-empty and tx_en=1, the FSM SHALL go directly to START with no idle cycle; otherwise it SHALL go to IDLE.
REQ-023 tx_en deasserted mid-frame SHALL let the current frame complete; no new frame SHALL start until tx_en=1.
REQ-024 txd SHALL be a registered output; if a byte is accepted at edge E into an empty FIFO while IDLE and tx_en=1, txd SHALL be 0 from edge E+1.
REQ-025 tx_busy SHALL be (state != IDLE) || (fifo_level != 0), registered-consistent with the state and level.

Reset
REQ-026 On rst: state=IDLE, txd=1, FIFO empty, fifo_level=0, tx_ready=1, tx_busy=0, and the counters and shift register SHALL be zero.
REQ-027 Reset asserted mid-frame SHALL abort the frame immediately with txd=1 and SHALL discard the FIFO contents.

Structure
REQ-028 Package uart_pkg SHALL hold the tx state enum and the register offset enum (CTRL 0, STATUS 1, BAUD 2, TXDATA 3, RXDATA 4), so the bus slave can share them.
REQ-029 The FIFO SHALL be a sub-module sync_fifo, parameterised by width and depth, with push/pop/full/empty/level.

Verification
REQ-030 baud_div=4, push 0xA5 -> txd sequence 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles, 40 cycles total, then tx_busy=0.
REQ-031 tx_en=0, push 5 bytes -> tx_ready=0 after 4 accepts, fifo_level=4, 5th byte held by the source; set tx_en=1 -> 5 frames are transmitted.
REQ-032 baud_div=2, push 0x00 then 0xFF back-to-back -> 40 cycles of continuous frames with no idle cycle between the STOP bit and the next START bit.
REQ-033 baud_div=0, push 0x01 -> each bit lasts 1 cycle, frame is 10 cycles.
REQ-034 baud_div=8, baud_div changed to 3 during DATA -> current frame keeps the 8-cycle bit period; the next frame uses 3.
REQ-035 Assert rst at cycle 15 of a frame with 2 bytes queued -> txd=1 immediately, fifo_level=0, no further frames transmitted.
